regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_scoreboard.sv | 72 +++++++
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the pipelined CPU register file and the hazard
//   unit that sits next to it.
//   - DEFAULT_WIDTH / DEFAULT_NREGS : default register width and register count
//   - MAX_NREGS                     : largest register count the popcount helper handles
//   - popcount()                    : number of set bits in a busy vector
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_NREGS = 32;
    localparam int MAX_NREGS     = 1024;

    // Callers zero-extend narrower busy vectors up to MAX_NREGS bits.
    function automatic logic [15:0] popcount(input logic [MAX_NREGS-1:0] vec);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < MAX_NREGS; i++) begin
            n = n + 16'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register busy vector that tracks in-flight producers, plus a
//   registered count of busy registers.
//   Ports:
//     clk, reset_n            clock, asynchronous active-low reset
//     IssueRegister/Valid     destination of the instruction issuing now (sets busy)
//     WriteRegister/RegWrite  writeback destination (clears busy)
//     busy                    current busy vector, one bit per register
//     BusyCount               popcount of busy, updated at each edge
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int ZERO_REG = NREGS - 1,
    parameter int AW       = $clog2(NREGS),
    parameter int CW       = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    IssueRegister,
    input  logic             IssueValid,
    input  logic [AW-1:0]    WriteRegister,
    input  logic             RegWrite,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    BusyCount
);

    logic [NREGS-1:0]     busy_d;
    logic [NREGS-1:0]     busy_q;
    logic [CW-1:0]        count_d;
    logic [CW-1:0]        count_q;
    logic [MAX_NREGS-1:0] busyWide;

    // Next busy vector. An issue beats a write to the same register because
    // the issuing instruction is a newer producer than the one retiring.
    // The zero register never has a producer to wait for.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (r == ZERO_REG) begin
                busy_d[r] = 1'b0;
            end else if (IssueValid && IssueRegister == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (RegWrite && WriteRegister == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Count is taken from the next vector so that after every edge the
    // registered count matches the registered vector exactly.
    always_comb begin
        busyWide            = '0;
        busyWide[NREGS-1:0] = busy_d;
        count_d             = CW'(popcount(busyWide));
    end

    // Busy vector and count state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy      = busy_q;
    assign BusyCount = count_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
//   General-purpose register file with a write scoreboard for the pipelined CPU.
//   NREAD combinational read ports, one synchronous write port, a hardwired
//   zero register, optional write-to-read bypass and a busy vector for RAW
//   hazard stalls.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     ReadRegister[NREAD]          read address per port
//     ReadData[NREAD]              read data per port (combinational)
//     ReadBusy[NREAD]              addressed register still has a pending producer
//     WriteRegister/Data, RegWrite writeback port; RegWrite also retires busy
//     IssueRegister, IssueValid    destination of the instruction issuing now
//     BusyCount                    number of busy registers (registered)
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NREGS    = DEFAULT_NREGS,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = NREGS - 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS),
    parameter int CW       = $clog2(NREGS + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREAD-1:0][AW-1:0]   ReadRegister,
    output logic [NREAD-1:0][WIDTH-1:0] ReadData,
    output logic [NREAD-1:0]           ReadBusy,
    input  logic [AW-1:0]              WriteRegister,
    input  logic [WIDTH-1:0]           WriteData,
    input  logic                       RegWrite,
    input  logic [AW-1:0]              IssueRegister,
    input  logic                       IssueValid,
    output logic [CW-1:0]              BusyCount
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREAD-1:0] bypassHit;

    // Storage: one flop bank per architectural register except the zero
    // register, which is a constant.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == ZERO_REG) begin : g_zero
            assign regs_q[r] = '0;
        end else begin : g_store
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    regs_q[r] <= '0;
                end else if (RegWrite && WriteRegister == AW'(r)) begin
                    regs_q[r] <= WriteData;
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW),
        .CW       (CW)
    ) u_scoreboard (
        .clk           (clk),
        .reset_n       (reset_n),
        .IssueRegister (IssueRegister),
        .IssueValid    (IssueValid),
        .WriteRegister (WriteRegister),
        .RegWrite      (RegWrite),
        .busy          (busy),
        .BusyCount     (BusyCount)
    );

    // Read ports. Forwarding is suppressed while reset is asserted because a
    // write in that cycle is lost and must not appear on the read side.
    // A forwarded read also hides the busy bit: the value is arriving now.
    always_comb begin
        bypassHit = '0;
        ReadData  = '0;
        ReadBusy  = '0;
        for (int k = 0; k < NREAD; k++) begin
            bypassHit[k] = (BYPASS != 0) && reset_n && RegWrite &&
                           (WriteRegister == ReadRegister[k]);
            if (ReadRegister[k] == AW'(ZERO_REG)) begin
                ReadData[k] = '0;
                ReadBusy[k] = 1'b0;
            end else begin
                ReadData[k] = bypassHit[k] ? WriteData : regs_q[ReadRegister[k]];
                ReadBusy[k] = busy[ReadRegister[k]] && !bypassHit[k];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Directed bench for regfile_sb. Two instances share the same stimulus:
//   dutB with write bypass enabled, dutN without it.
module tb_regfile_sb;

    localparam int WIDTH = 64;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic                        clk;
    logic                        resetN;
    logic [NREAD-1:0][AW-1:0]    readReg;
    logic [AW-1:0]               writeReg;
    logic [WIDTH-1:0]            writeData;
    logic                        regWrite;
    logic [AW-1:0]               issueReg;
    logic                        issueValid;

    logic [NREAD-1:0][WIDTH-1:0] rdB, rdN;
    logic [NREAD-1:0]            busyB, busyN;
    logic [CW-1:0]               countB, countN;

    int testsRun    = 0;
    int testsFailed = 0;

    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) dutB (
        .clk           (clk),
        .reset_n       (resetN),
        .ReadRegister  (readReg),
        .ReadData      (rdB),
        .ReadBusy      (busyB),
        .WriteRegister (writeReg),
        .WriteData     (writeData),
        .RegWrite      (regWrite),
        .IssueRegister (issueReg),
        .IssueValid    (issueValid),
        .BusyCount     (countB)
    );

    regfile_sb #(.WIDTH(WIDTH), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) dutN (
        .clk           (clk),
        .reset_n       (resetN),
        .ReadRegister  (readReg),
        .ReadData      (rdN),
        .ReadBusy      (busyN),
        .WriteRegister (writeReg),
        .WriteData     (writeData),
        .RegWrite      (regWrite),
        .IssueRegister (issueReg),
        .IssueValid    (issueValid),
        .BusyCount     (countN)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                                 input logic wEn, input logic [AW-1:0] wReg,
                                 input logic [WIDTH-1:0] wData,
                                 input logic iEn, input logic [AW-1:0] iReg);
        readReg[0] = r0;
        readReg[1] = r1;
        regWrite   = wEn;
        writeReg   = wReg;
        writeData  = wData;
        issueValid = iEn;
        issueReg   = iReg;
        #1;
    endtask

    // Advance past the next rising edge, sampling 1 ns after it.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        applyStimulus(5'd3, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);

        // Reset state
        checkOutput("reset_rd0", rdB[0], 64'h0);
        checkOutput("reset_rd1", rdN[1], 64'h0);
        checkOutput("reset_busy", {62'h0, busyB}, 64'h0);
        checkOutput("reset_count", {58'h0, countB}, 64'h0);

        nextCycle();
        resetN = 1'b1;
        nextCycle();

        // Write X3; bypass instance forwards, the other still shows old data
        applyStimulus(5'd3, 5'd3, 1'b1, 5'd3, 64'hDEADBEEF_00000001, 1'b0, 5'd0);
        checkOutput("x3_bypass_same", rdB[0], 64'hDEADBEEF_00000001);
        checkOutput("x3_nobypass_same", rdN[0], 64'h0);
        nextCycle();
        applyStimulus(5'd3, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("x3_port0", rdB[0], 64'hDEADBEEF_00000001);
        checkOutput("x3_port1", rdB[1], 64'hDEADBEEF_00000001);
        checkOutput("x3_nb_port0", rdN[0], 64'hDEADBEEF_00000001);
        checkOutput("x3_nb_port1", rdN[1], 64'hDEADBEEF_00000001);
        applyStimulus(5'd31, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("zero_read", rdB[0], 64'h0);

        // Write to the zero register is dropped, even on the bypass path
        applyStimulus(5'd31, 5'd31, 1'b1, 5'd31, 64'h1234, 1'b0, 5'd0);
        checkOutput("x31_bypass", rdB[0], 64'h0);
        nextCycle();
        applyStimulus(5'd31, 5'd31, 1'b0, 5'd0, '0, 1'b1, 5'd31);
        checkOutput("x31_read", rdB[0], 64'h0);
        checkOutput("x31_count", {58'h0, countB}, 64'h0);
        nextCycle();
        applyStimulus(5'd31, 5'd31, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("x31_issue_count", {58'h0, countB}, 64'h0);
        checkOutput("x31_issue_busy", {63'h0, busyB[0]}, 64'h0);

        // Bypass timing on X5
        applyStimulus(5'd5, 5'd3, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0);
        checkOutput("x5_bypass_same", rdB[0], 64'hAA);
        checkOutput("x5_nobypass_same", rdN[0], 64'h0);
        nextCycle();
        applyStimulus(5'd5, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("x5_nobypass_next", rdN[0], 64'hAA);

        // Issue X7, reissue, then retire
        applyStimulus(5'd7, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd7);
        checkOutput("x7_busy_before", {63'h0, busyB[0]}, 64'h0);
        nextCycle();
        applyStimulus(5'd7, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd7);
        checkOutput("x7_busy_b", {63'h0, busyB[0]}, 64'h1);
        checkOutput("x7_busy_n", {63'h0, busyN[0]}, 64'h1);
        checkOutput("x7_count", {58'h0, countB}, 64'h1);
        nextCycle();
        applyStimulus(5'd7, 5'd3, 1'b1, 5'd7, 64'h77, 1'b0, 5'd0);
        checkOutput("x7_reissue_count", {58'h0, countB}, 64'h1);
        checkOutput("x7_wr_busy_b", {63'h0, busyB[0]}, 64'h0);
        checkOutput("x7_wr_busy_n", {63'h0, busyN[0]}, 64'h1);
        checkOutput("x7_wr_count_same", {58'h0, countN}, 64'h1);
        nextCycle();
        applyStimulus(5'd7, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("x7_count_next", {58'h0, countB}, 64'h0);
        checkOutput("x7_busy_n_next", {63'h0, busyN[0]}, 64'h0);
        checkOutput("x7_data", rdN[0], 64'h77);

        // Issue and write X9 in the same cycle: issue wins
        applyStimulus(5'd9, 5'd3, 1'b0, 5'd0, '0, 1'b1, 5'd9);
        nextCycle();
        applyStimulus(5'd9, 5'd3, 1'b1, 5'd9, 64'h99, 1'b1, 5'd9);
        checkOutput("x9_pre_count", {58'h0, countB}, 64'h1);
        checkOutput("x9_same_busy_b", {63'h0, busyB[0]}, 64'h0);
        nextCycle();
        applyStimulus(5'd9, 5'd3, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("x9_data", rdN[0], 64'h99);
        checkOutput("x9_busy", {63'h0, busyB[0]}, 64'h1);
        checkOutput("x9_count", {58'h0, countB}, 64'h1);

        // Issue X1, X2, X4, then reset mid-cycle
        applyStimulus(5'd1, 5'd9, 1'b0, 5'd0, '0, 1'b1, 5'd1);
        nextCycle();
        applyStimulus(5'd1, 5'd9, 1'b0, 5'd0, '0, 1'b1, 5'd2);
        nextCycle();
        applyStimulus(5'd1, 5'd9, 1'b0, 5'd0, '0, 1'b1, 5'd4);
        nextCycle();
        applyStimulus(5'd3, 5'd9, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        checkOutput("multi_count", {58'h0, countB}, 64'h4);
        checkOutput("multi_busy1", {63'h0, busyB[1]}, 64'h1);
        #2;
        resetN = 1'b0;
        applyStimulus(5'd3, 5'd9, 1'b1, 5'd3, 64'h5555, 1'b1, 5'd6);
        checkOutput("rst_mid_rd0", rdB[0], 64'h0);
        checkOutput("rst_mid_count", {58'h0, countB}, 64'h0);
        checkOutput("rst_mid_busy1", {63'h0, busyB[1]}, 64'h0);
        nextCycle();
        applyStimulus(5'd3, 5'd5, 1'b0, 5'd0, '0, 1'b0, 5'd0);
        #2;
        resetN = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("post_rst_x3", rdB[0], 64'h0);
        checkOutput("post_rst_x5", rdN[1], 64'h0);
        checkOutput("post_rst_count", {58'h0, countB}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
